img_matrix_3x3_gen: RTL and testbench
=====================================

IMG_MATRIX_3X3_GEN -- requirements
Module: img_matrix_3x3_gen

Interface
REQ-001 The block SHALL have parameter IMG_H_DISP, default 640, giving active pixels per line.
REQ-002 The block SHALL have parameter IMG_V_DISP, default 480, giving active lines per frame.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port per_img_vsync, input, 1 bit: frame valid.
REQ-006 The block SHALL have port per_img_href, input, 1 bit: pixel valid; exactly IMG_H_DISP cycles per line.
REQ-007 The block SHALL have port per_img_gray, input, 8 bits: pixel value, sampled when per_img_href=1.
REQ-008 The block SHALL have port matrix_img_vsync, output, 1 bit: output frame valid.
REQ-009 The block SHALL have port matrix_img_href, output, 1 bit: window valid.
REQ-010 The block SHALL have ports matrix_p11..matrix_p33, output, 8 bits each: 3x3 window; pRC is row R (1=above, 2=centre, 3=below) and column C (1=left, 2=centre, 3=right).

Function
REQ-011 The block SHALL output, per window, the pixels at (r-1..r+1, c-1..c+1) around centre (r,c), with the coordinates clamped to [0,IMG_V_DISP-1] x [0,IMG_H_DISP-1] (edge replication).
REQ-012 The block SHALL hold two IMG_H_DISP x 8 line buffers storing lines r-1 and r, written in column order.
REQ-013 The block SHALL count columns 0..IMG_H_DISP-1 on href=1 and count lines on each href falling edge; both counters clear on the per_img_vsync rising edge.
REQ-014 The FSM SHALL have states IDLE, PRIME, STREAM and FLUSH: IDLE->PRIME on vsync rise; PRIME->STREAM on the falling edge of line 0 href; STREAM->FLUSH on the falling edge of line IMG_V_DISP-1 href; FLUSH->IDLE after IMG_H_DISP flush cycles.
REQ-015 Input line 0 (PRIME) SHALL only fill the buffers and SHALL produce no output href.
REQ-016 In STREAM, input line r+1 SHALL produce output line r, with the source href equal to per_img_href.
REQ-017 FLUSH SHALL generate an internal href for IMG_H_DISP consecutive cycles, starting on the first cycle after line IMG_V_DISP-1 href falls, and SHALL produce output line IMG_V_DISP-1 with row 3 replicated from row 2.
REQ-018 matrix_img_href SHALL equal the source href delayed by exactly 3 cycles, giving IMG_H_DISP contiguous cycles per output line.
REQ-019 The k-th matrix_img_href cycle of a line SHALL present centre column k; at k=0 column 1 SHALL replicate column 2, and at k=IMG_H_DISP-1 column 3 SHALL replicate column 2.
REQ-020 matrix_img_vsync SHALL rise 3 cycles after per_img_vsync rises and SHALL fall on the cycle after the last FLUSH output pixel.
REQ-021 If per_img_vsync falls before IMG_V_DISP lines are complete, the block SHALL enter IDLE without a flush, and matrix_img_vsync SHALL fall 3 cycles after the input vsync falls.
REQ-022 A per_img_vsync rising edge during FLUSH SHALL abort the flush (href low on the next cycle), restart the counters and enter PRIME.
REQ-023 Window outputs SHALL be registered and SHALL hold their last value while matrix_img_href=0.

Reset
REQ-024 While rst_n=0 at a clock edge, the FSM SHALL be IDLE, the counters 0, and matrix_img_vsync, matrix_img_href and all matrix_pXX outputs 0.
REQ-025 Line buffer contents SHALL NOT need a reset.
REQ-026 Reset asserted mid-frame SHALL discard the frame; after release, the block SHALL wait for the next per_img_vsync rising edge.

Verification (IMG_H_DISP=4, IMG_V_DISP=3, pixel=16*r+c, 10-cycle line blanking)
REQ-027 Stream one frame -> first matrix_img_href 3 cycles after line 1 href rises; window at (0,0) = p11..p33 = 00,00,01,00,00,01,10,10,11.
REQ-028 Same frame, centre (1,2) -> p11..p33 = 01,02,03,11,12,13,21,22,23.
REQ-029 Same frame, FLUSH line -> 4 href cycles starting 4 cycles after line 2 href falls; (2,3) = 12,13,13,22,23,23,22,23,23; matrix_img_vsync falls on the next cycle.
REQ-030 Per frame -> exactly 3 output lines of 4 contiguous href cycles; no output during line 0.
REQ-031 per_img_vsync dropped after line 1 -> no flush; matrix_img_vsync low 3 cycles later; the next frame outputs are correct.
REQ-032 rst_n pulsed low for 1 cycle mid-line 1 -> all outputs 0 on the next cycle; no href until the next frame; the following frame matches REQ-027.

Source files
------------

// File: rtl/img_matrix_3x3_gen.sv
// 3x3 sliding-window generator for a raster gray stream, with edge replication.
// Two line buffers hold the previous two lines; a flush pass emits the last line after the frame.
module img_matrix_3x3_gen #(
  parameter int IMG_H_DISP = 640,
  parameter int IMG_V_DISP = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_img_vsync,
  input  logic       per_img_href,
  input  logic [7:0] per_img_gray,
  output logic       matrix_img_vsync,
  output logic       matrix_img_href,
  output logic [7:0] matrix_p11,
  output logic [7:0] matrix_p12,
  output logic [7:0] matrix_p13,
  output logic [7:0] matrix_p21,
  output logic [7:0] matrix_p22,
  output logic [7:0] matrix_p23,
  output logic [7:0] matrix_p31,
  output logic [7:0] matrix_p32,
  output logic [7:0] matrix_p33,
  output logic [1:0] fsm_state
);

  localparam int CW = (IMG_H_DISP > 1) ? $clog2(IMG_H_DISP) : 1;
  localparam int LW = $clog2(IMG_V_DISP + 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_H_DISP - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(IMG_V_DISP - 1);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, FLUSH} state_t;
  state_t state, state_nxt;

  logic          vsync_d, href_d;
  logic          vsync_rise, href_fall;
  logic [CW-1:0] col_cnt, flush_cnt, rd_addr;
  logic [LW-1:0] line_cnt;
  logic          src_v, src_vs, wr_prime, wr_stream, flushing;

  logic [7:0] line_buf0 [0:IMG_H_DISP-1];
  logic [7:0] line_buf1 [0:IMG_H_DISP-1];

  logic [7:0] c_top, c_mid, c_bot;
  logic [7:0] a_top, a_mid, a_bot;
  logic [7:0] b_top, b_mid, b_bot;
  logic       v1, v2, first1, last1, first2, last2;
  logic [2:0] vs_pipe;

  assign vsync_rise = per_img_vsync & ~vsync_d;
  assign href_fall  = ~per_img_href & href_d;
  assign rd_addr    = flushing ? flush_cnt : col_cnt;
  assign fsm_state  = state;
  assign matrix_img_vsync = vs_pipe[2];

  // vsync_d tracks the input during reset so a frame already in progress is not mistaken for a new one
  always_ff @(posedge clk) begin
    vsync_d <= per_img_vsync;
    if (!rst_n) href_d <= 1'b0;
    else        href_d <= per_img_href;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (vsync_rise) state_nxt = PRIME;
      PRIME:  if (!per_img_vsync) state_nxt = IDLE;
              else if (href_fall) state_nxt = STREAM;
      STREAM: if (href_fall && line_cnt == LINE_LAST) state_nxt = FLUSH;
              else if (!per_img_vsync) state_nxt = IDLE;
      FLUSH:  if (vsync_rise) state_nxt = PRIME;
              else if (flush_cnt == COL_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    src_v     = 1'b0;
    src_vs    = 1'b0;
    wr_prime  = 1'b0;
    wr_stream = 1'b0;
    flushing  = 1'b0;
    case (state)
      IDLE:   src_vs = vsync_rise;
      PRIME: begin
        src_vs   = per_img_vsync;
        wr_prime = per_img_href;
      end
      STREAM: begin
        src_vs    = per_img_vsync | (href_fall & (line_cnt == LINE_LAST));
        src_v     = per_img_href;
        wr_stream = per_img_href;
      end
      FLUSH: begin
        src_vs   = 1'b1;
        src_v    = 1'b1;
        flushing = 1'b1;
      end
      default: src_vs = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_cnt   <= '0;
      line_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (vsync_rise)        col_cnt <= '0;
      else if (per_img_href) col_cnt <= (col_cnt == COL_LAST) ? '0 : col_cnt + CW'(1);
      else                   col_cnt <= '0;
      if (vsync_rise)     line_cnt <= '0;
      else if (href_fall) line_cnt <= line_cnt + LW'(1);
      if (state == FLUSH && state_nxt == FLUSH) flush_cnt <= flush_cnt + CW'(1);
      else                                      flush_cnt <= '0;
    end
  end

  // Line 0 seeds both buffers so the row above line 0 replicates line 0
  always_ff @(posedge clk) begin
    if (wr_prime) begin
      line_buf0[col_cnt] <= per_img_gray;
      line_buf1[col_cnt] <= per_img_gray;
    end else if (wr_stream) begin
      line_buf0[col_cnt] <= line_buf1[col_cnt];
      line_buf1[col_cnt] <= per_img_gray;
    end
    if (src_v) begin
      c_top <= line_buf0[rd_addr];
      c_mid <= line_buf1[rd_addr];
      c_bot <= flushing ? line_buf1[rd_addr] : per_img_gray;
    end
    if (v1) begin
      a_top <= b_top;
      a_mid <= b_mid;
      a_bot <= b_bot;
      b_top <= c_top;
      b_mid <= c_mid;
      b_bot <= c_bot;
    end
  end

  // Window is built from b (centre), a (left) and c (the column just fetched, right)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0;
      first1 <= 1'b0; last1 <= 1'b0; first2 <= 1'b0; last2 <= 1'b0;
      vs_pipe <= '0;
      matrix_img_href <= 1'b0;
      matrix_p11 <= '0; matrix_p12 <= '0; matrix_p13 <= '0;
      matrix_p21 <= '0; matrix_p22 <= '0; matrix_p23 <= '0;
      matrix_p31 <= '0; matrix_p32 <= '0; matrix_p33 <= '0;
    end else begin
      v1     <= src_v;
      first1 <= (rd_addr == '0);
      last1  <= (rd_addr == COL_LAST);
      v2     <= v1;
      first2 <= first1;
      last2  <= last1;
      matrix_img_href <= v2;
      vs_pipe <= {vs_pipe[1:0], src_vs};
      if (v2) begin
        matrix_p11 <= first2 ? b_top : a_top;
        matrix_p21 <= first2 ? b_mid : a_mid;
        matrix_p31 <= first2 ? b_bot : a_bot;
        matrix_p12 <= b_top;
        matrix_p22 <= b_mid;
        matrix_p32 <= b_bot;
        matrix_p13 <= last2 ? b_top : c_top;
        matrix_p23 <= last2 ? b_mid : c_mid;
        matrix_p33 <= last2 ? b_bot : c_bot;
      end
    end
  end

endmodule

// File: tb/tb_img_matrix_3x3_gen.sv
// Bench for img_matrix_3x3_gen: random frames checked against a clamped-window image model,
// plus output timing, truncated frames and a mid-frame reset.
module tb_img_matrix_3x3_gen;
  localparam int H = 4;
  localparam int V = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic [7:0] gray = 8'h00;
  logic       mv, mh;
  logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic [1:0] fsm_state;

  img_matrix_3x3_gen #(.IMG_H_DISP(H), .IMG_V_DISP(V)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_img_vsync(vsync), .per_img_href(href), .per_img_gray(gray),
    .matrix_img_vsync(mv), .matrix_img_href(mh),
    .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
    .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
    .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
    .fsm_state(fsm_state)
  );

  // clock / reset / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [71:0] exp_q[$];
  int exp_start_q[$];
  int exp_vr_q[$];
  int exp_vf_q[$];
  logic [7:0] img [V][H];

  wire [71:0] obs = {p11, p12, p13, p21, p22, p23, p31, p32, p33};

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int clampi(input int x, input int hi);
    return (x < 0) ? 0 : ((x > hi) ? hi : x);
  endfunction

  // Reference window: 3x3 neighbourhood with coordinates clamped to the image
  function automatic logic [71:0] win(input int r, input int c);
    logic [71:0] w = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        w = {w[63:0], img[clampi(r + dr, V - 1)][clampi(c + dc, H - 1)]};
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard / monitor, sampled mid-cycle
  logic        mh_q = 1'b0, mv_q = 1'b0, rst_q = 1'b0;
  logic [71:0] win_q = '0;
  int          run = 0;

  always @(negedge clk) begin
    if (mh && !mh_q) check("line_start", cyc, exp_start_q.size() > 0 ? exp_start_q.pop_front() : -1);
    if (mh) begin
      run++;
      check("window", obs, exp_q.size() > 0 ? exp_q.pop_front() : 72'bx);
    end else begin
      if (mh_q) begin
        check("line_len", run, H);
        run = 0;
      end
      if (rst_q) check("hold", obs, win_q);
    end
    if (mv && !mv_q) check("vsync_rise", cyc, exp_vr_q.size() > 0 ? exp_vr_q.pop_front() : -1);
    if (!mv && mv_q) check("vsync_fall", cyc, exp_vf_q.size() > 0 ? exp_vf_q.pop_front() : -1);
    mh_q  = mh;
    mv_q  = mv;
    rst_q = rst_n;
    win_q = obs;
  end

  // driver: one frame of n_lines lines, optional 1-cycle reset during line 1 column 1
  task automatic drive_frame(input int n_lines, input bit do_rst, input bit pattern);
    int f;
    bit full_out;
    full_out = (n_lines == V) && !do_rst;
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        img[r][c] = pattern ? 8'(16 * r + c) : 8'($urandom_range(0, 255));
    tick();
    vsync = 1'b1;
    href  = 1'b0;
    exp_vr_q.push_back(cyc + 3);
    repeat (4) tick();
    for (int l = 0; l < n_lines; l++) begin
      for (int c = 0; c < H; c++) begin
        tick();
        href = 1'b1;
        gray = img[l][c];
        if (do_rst && l == 1 && c == 1) begin
          rst_n = 1'b0;
          exp_vf_q.push_back(cyc + 1);
        end else begin
          rst_n = 1'b1;
        end
        if (c == 0 && l >= 1 && !do_rst) begin
          exp_start_q.push_back(cyc + 3);
          for (int k = 0; k < H; k++) exp_q.push_back(win(l - 1, k));
        end
        if (do_rst && l == 1 && c == 2) begin
          @(negedge clk);
          check("rst_win", obs, '0);
          check("rst_flags", {mv, mh}, '0);
        end
      end
      for (int b = 0; b < 10; b++) begin
        tick();
        href = 1'b0;
        if (b == 0) begin
          f = cyc;
          if (full_out && l == V - 1) begin
            exp_start_q.push_back(f + 4);
            for (int k = 0; k < H; k++) exp_q.push_back(win(V - 1, k));
            exp_vf_q.push_back(f + 4 + H);
          end
        end
      end
    end
    tick();
    vsync = 1'b0;
    if (n_lines < V && !do_rst) exp_vf_q.push_back(cyc + 3);
    repeat (8) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_win", obs, '0);
    check("reset_flags", {mv, mh}, '0);
    repeat (3) tick();

    drive_frame(V, 1'b0, 1'b1);
    drive_frame(V, 1'b0, 1'b0);
    drive_frame(2, 1'b0, 1'b0);
    drive_frame(V, 1'b0, 1'b0);
    drive_frame(V, 1'b1, 1'b0);
    drive_frame(V, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive_frame(V, 1'b0, 1'b0);

    repeat (20) tick();
    check("win_left", exp_q.size(), 0);
    check("start_left", exp_start_q.size(), 0);
    check("vrise_left", exp_vr_q.size(), 0);
    check("vfall_left", exp_vf_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
